// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the hazard scoreboard.
//   - FWD_* : operand-mux select encoding driven on fwd_sel1/fwd_sel2.
//   - sb_state_e : scoreboard FSM state (ST_RUN / ST_STALL).
//   - stage_t : one in-flight pipeline entry {valid, dst, wr, load}.
//   HZ_AW is the register address width baked into stage_t; the top-level
//   AW parameter must equal it.
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int HZ_AW = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic             valid;
        logic [HZ_AW-1:0] dst;
        logic             wr;
        logic             load;
    } stage_t;

    // A bubble is an all-zero entry, so an empty WB stage also presents dst=0.
    localparam stage_t STAGE_BUBBLE = '0;

    // True when a used source operand names the register this entry will write.
    function automatic logic src_match(input logic             use_src,
                                       input logic [HZ_AW-1:0] src,
                                       input stage_t           st);
        return use_src & st.valid & st.wr & (st.dst == src);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// ---------------------------------------------------------------------------
// hazard_stage_reg
//   One pipeline-entry register of the scoreboard (used for EX, MEM, WB).
//   Ports:
//     clk       in   clock, posedge
//     reset     in   synchronous active-high reset, empties the entry
//     bubble_i  in   load an empty entry instead of entry_i
//     entry_i   in   next entry (stage_t)
//     entry_o   out  registered entry (stage_t)
// ---------------------------------------------------------------------------
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble_i,
    input  stage_t entry_i,
    output stage_t entry_o
);

    stage_t entry_q;
    stage_t entry_d;

    always_comb begin
        entry_d = entry_i;
        if (bubble_i) begin
            entry_d = STAGE_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= STAGE_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Register-file access sequencer for a 5-stage pipe. Tracks destination
//   registers in flight in EX, MEM and WB, decides per decode cycle whether
//   decode must stall and which forwarding source feeds each read operand,
//   and drives the register-file write port from the WB entry.
//
//   Build option: define HAZARD_FWD_EN to enable EX/MEM forwarding (only a
//   load-use stalls). Without it, fwd_sel* stay 0 and any EX/MEM producer
//   match stalls until that producer reaches WB.
//
//   Ports:
//     clk, reset               clock; synchronous active-high reset
//     id_valid                 decode slot holds a real instruction
//     id_src1/2, id_use1/2     source registers and their use flags
//     id_dst, id_wr, id_load   destination, writes-dst flag, is-load flag
//     flush                    kill the decode slot (branch/jump taken)
//     id_stall                 hold PC and IF/ID, bubble into EX
//     fwd_sel1/2               operand source: 0 regfile, 1 EX, 2 MEM
//     wb_dst, wb_we            register-file write address / enable
//     stall_cycles             saturating count of stalled cycles
//     sb_state                 FSM state: 0 RUN, 1 STALL
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_src1,
    input  logic [AW-1:0]    id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             flush,
    output logic             id_stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [AW-1:0]    wb_dst,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             sb_state
);

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int NSTG    = 3;

    localparam logic [AW:0]      NREG_LIM = (AW + 1)'(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // -----------------------------------------------------------------------
    // Pipeline of in-flight entries
    // -----------------------------------------------------------------------
    stage_t           dec_entry;
    stage_t           stage_d [NSTG];
    stage_t           stage_q [NSTG];
    logic [NSTG-1:0]  bubble_vec;
    logic             hazard;

    // Writes to an address beyond the implemented register count are not
    // tracked: nothing can ever read that register back.
    always_comb begin
        dec_entry       = STAGE_BUBBLE;
        dec_entry.valid = id_valid;
        dec_entry.dst   = id_dst;
        dec_entry.wr    = id_wr & ({1'b0, id_dst} < NREG_LIM);
        dec_entry.load  = id_load;
    end

    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
            if (gi == STG_EX) begin : g_ex_in
                assign stage_d[gi]    = dec_entry;
                assign bubble_vec[gi] = ~(id_valid & ~id_stall & ~flush);
            end else begin : g_shift_in
                assign stage_d[gi]    = stage_q[gi-1];
                assign bubble_vec[gi] = 1'b0;
            end

            hazard_stage_reg u_stage (
                .clk      (clk),
                .reset    (reset),
                .bubble_i (bubble_vec[gi]),
                .entry_i  (stage_d[gi]),
                .entry_o  (stage_q[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Source matching against EX and MEM. WB never needs forwarding: the
    // register file writes on posedge and reads on negedge.
    // -----------------------------------------------------------------------
    logic m1_ex;
    logic m1_mem;
    logic m2_ex;
    logic m2_mem;

    assign m1_ex  = id_valid & src_match(id_use1, id_src1, stage_q[STG_EX]);
    assign m1_mem = id_valid & src_match(id_use1, id_src1, stage_q[STG_MEM]);
    assign m2_ex  = id_valid & src_match(id_use2, id_src2, stage_q[STG_EX]);
    assign m2_mem = id_valid & src_match(id_use2, id_src2, stage_q[STG_MEM]);

`ifdef HAZARD_FWD_EN
    // Youngest producer wins: EX before MEM.
    always_comb begin
        fwd_sel1 = FWD_RF;
        fwd_sel2 = FWD_RF;
        if (m1_ex) begin
            fwd_sel1 = FWD_EX;
        end else if (m1_mem) begin
            fwd_sel1 = FWD_MEM;
        end
        if (m2_ex) begin
            fwd_sel2 = FWD_EX;
        end else if (m2_mem) begin
            fwd_sel2 = FWD_MEM;
        end
    end

    // A load in EX has no data yet; one bubble moves it to MEM where its
    // result can be forwarded.
    assign hazard = (m1_ex | m2_ex) & stage_q[STG_EX].load;
`else
    assign fwd_sel1 = FWD_RF;
    assign fwd_sel2 = FWD_RF;

    // No bypass paths: wait until the producer has reached WB.
    assign hazard   = m1_ex | m1_mem | m2_ex | m2_mem;
`endif

    // Flush wins: the killed slot becomes a bubble instead of stalling.
    assign id_stall = hazard & ~flush;

    // -----------------------------------------------------------------------
    // Register-file write port
    // -----------------------------------------------------------------------
    assign wb_we  = stage_q[STG_WB].valid & stage_q[STG_WB].wr;
    assign wb_dst = stage_q[STG_WB].dst;

    // Load flags only matter in EX (and only with forwarding enabled).
    logic unused_load_bits;
    assign unused_load_bits = ^{stage_q[STG_EX].load, stage_q[STG_MEM].load,
                                stage_q[STG_WB].load};

    // -----------------------------------------------------------------------
    // RUN/STALL FSM
    // -----------------------------------------------------------------------
    sb_state_e state_q;
    sb_state_e state_d;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (id_stall)  state_d = ST_STALL;
                ST_STALL: if (!id_stall) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign sb_state = state_q;

    // -----------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (id_stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. Expectations follow the build:
//   with HAZARD_FWD_EN the forwarding results are expected, otherwise the
//   stall-until-WB results. The counter is instantiated 8 bits wide so that
//   saturation is reached in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int AW    = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [AW-1:0]    id_src1;
    logic [AW-1:0]    id_src2;
    logic             id_use1;
    logic             id_use2;
    logic [AW-1:0]    id_dst;
    logic             id_wr;
    logic             id_load;
    logic             flush;
    logic             id_stall;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [AW-1:0]    wb_dst;
    logic             wb_we;
    logic [CNT_W-1:0] stall_cycles;
    logic             sb_state;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG  (8),
        .AW    (AW),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .id_dst       (id_dst),
        .id_wr        (id_wr),
        .id_load      (id_load),
        .flush        (flush),
        .id_stall     (id_stall),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .wb_dst       (wb_dst),
        .wb_we        (wb_we),
        .stall_cycles (stall_cycles),
        .sb_state     (sb_state)
    );

    int errors     = 0;
    int checks     = 0;
    int exp_stalls = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[%0t] check %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    // Posedge, then step off the edge before touching inputs or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [AW-1:0] s1, input logic u1,
                           input logic [AW-1:0] s2, input logic u2,
                           input logic [AW-1:0] d, input logic w, input logic ld);
        id_valid = v;
        id_src1  = s1;
        id_use1  = u1;
        id_src2  = s2;
        id_use2  = u2;
        id_dst   = d;
        id_wr    = w;
        id_load  = ld;
        #1;
    endtask

    task automatic nop();
        flush = 1'b0;
        set_ins(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", id_stall, 0);
        chk("rst_sel1", fwd_sel1, 0);
        chk("rst_sel2", fwd_sel2, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_dst", wb_dst, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_state", sb_state, 0);

        // ---- ADD r1 ; ADD r2 <- r1, r3 ----
        set_ins(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0);
        chk("t1_prod_stall", id_stall, 0);
        tick();
        set_ins(1, 3'd1, 1, 3'd3, 1, 3'd2, 1, 0);
`ifdef HAZARD_FWD_EN
        chk("t1_stall", id_stall, 0);
        chk("t1_sel1", fwd_sel1, 1);
        chk("t1_sel2", fwd_sel2, 0);
        tick();
`else
        chk("t1_stall_a", id_stall, 1);
        chk("t1_sel1_a", fwd_sel1, 0);
        tick();
        chk("t1_stall_b", id_stall, 1);
        tick();
        chk("t1_stall_c", id_stall, 0);
        chk("t1_sel1_c", fwd_sel1, 0);
        chk("t1_wb_we", wb_we, 1);
        chk("t1_wb_dst", wb_dst, 1);
        tick();
        exp_stalls += 2;
`endif
        chk("t1_cnt", stall_cycles, exp_stalls);

        // ---- reader of r2 while r2 is in WB ----
        nop();
        tick();
        tick();
        set_ins(1, 3'd2, 1, 3'd0, 0, 3'd7, 0, 0);
        chk("t4_stall", id_stall, 0);
        chk("t4_sel1", fwd_sel1, 0);
        chk("t4_wb_we", wb_we, 1);
        chk("t4_wb_dst", wb_dst, 2);
        drain();

        // ---- LOAD r4 ; ADD r5 <- r4, r4 ----
        set_ins(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1);
        chk("t2_ld_stall", id_stall, 0);
        tick();
        set_ins(1, 3'd4, 1, 3'd4, 1, 3'd5, 1, 0);
        chk("t2_stall_a", id_stall, 1);
        chk("t2_state_a", sb_state, 0);
        tick();
`ifdef HAZARD_FWD_EN
        chk("t2_stall_b", id_stall, 0);
        chk("t2_sel1_b", fwd_sel1, 2);
        chk("t2_sel2_b", fwd_sel2, 2);
        chk("t2_state_b", sb_state, 1);
        tick();
        exp_stalls += 1;
`else
        chk("t2_stall_b", id_stall, 1);
        chk("t2_state_b", sb_state, 1);
        chk("t2_sel1_b", fwd_sel1, 0);
        tick();
        chk("t2_stall_c", id_stall, 0);
        chk("t2_sel2_c", fwd_sel2, 0);
        chk("t2_state_c", sb_state, 1);
        tick();
        exp_stalls += 2;
`endif
        chk("t2_state_end", sb_state, 0);
        chk("t2_cnt", stall_cycles, exp_stalls);
        drain();

        // ---- r6 written by EX and MEM entries ----
        set_ins(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0);
        tick();
        tick();
        set_ins(1, 3'd6, 0, 3'd6, 0, 3'd7, 1, 0);
        chk("t3_nouse_stall", id_stall, 0);
        chk("t3_nouse_sel1", fwd_sel1, 0);
        set_ins(0, 3'd6, 1, 3'd6, 1, 3'd7, 1, 0);
        chk("t3_novalid_stall", id_stall, 0);
        set_ins(1, 3'd0, 0, 3'd6, 1, 3'd7, 1, 0);
`ifdef HAZARD_FWD_EN
        chk("t3_ex_sel2", fwd_sel2, 1);
        chk("t3_ex_sel1", fwd_sel1, 0);
        chk("t3_ex_stall", id_stall, 0);
`else
        chk("t3_ex_stall", id_stall, 1);
        chk("t3_ex_sel2", fwd_sel2, 0);
`endif
        nop();
        tick();
        set_ins(1, 3'd6, 1, 3'd0, 0, 3'd7, 1, 0);
`ifdef HAZARD_FWD_EN
        chk("t3_mem_sel1", fwd_sel1, 2);
        chk("t3_mem_stall", id_stall, 0);
`else
        chk("t3_mem_stall", id_stall, 1);
        chk("t3_mem_sel1", fwd_sel1, 0);
`endif
        drain();

        // ---- load-use with flush in the same cycle ----
        set_ins(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1);
        tick();
        flush = 1'b1;
        set_ins(1, 3'd4, 1, 3'd0, 0, 3'd5, 1, 0);
        chk("t5_stall", id_stall, 0);
        tick();
        nop();
        chk("t5_state", sb_state, 0);
        tick();
        chk("t5_wb_we_ld", wb_we, 1);
        chk("t5_wb_dst_ld", wb_dst, 4);
        tick();
        chk("t5_wb_we_bub", wb_we, 0);
        chk("t5_cnt", stall_cycles, exp_stalls);
        drain();

        // ---- flush while in STALL forces RUN ----
        set_ins(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1);
        tick();
        set_ins(1, 3'd4, 1, 3'd0, 0, 3'd5, 1, 0);
        chk("tf_stall", id_stall, 1);
        tick();
        exp_stalls += 1;
        chk("tf_state_stall", sb_state, 1);
        flush = 1'b1;
        #1;
        chk("tf_flush_stall", id_stall, 0);
        tick();
        chk("tf_state_run", sb_state, 0);
        chk("tf_cnt", stall_cycles, exp_stalls);
        drain();

        // ---- repeated self-dependent load r1 <- r1: counting, then saturation ----
        set_ins(1, 3'd1, 1, 3'd0, 0, 3'd1, 1, 1);
        repeat (61) tick();
`ifdef HAZARD_FWD_EN
        exp_stalls += 30;
`else
        exp_stalls += 40;
`endif
        chk("t6_cnt_mid", stall_cycles, exp_stalls);
        repeat (700) tick();
        chk("t6_cnt_sat", stall_cycles, 8'hFF);

        // ---- reset asserted mid-stall ----
        drain();
        set_ins(1, 3'd1, 1, 3'd0, 0, 3'd1, 1, 1);
        tick();
        chk("t6_pre_stall", id_stall, 1);
        tick();
        chk("t6_pre_state", sb_state, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_stall", id_stall, 0);
        chk("t6_rst_sel1", fwd_sel1, 0);
        chk("t6_rst_wb_we", wb_we, 0);
        chk("t6_rst_wb_dst", wb_dst, 0);
        chk("t6_rst_cnt", stall_cycles, 0);
        chk("t6_rst_state", sb_state, 0);
        tick();
        chk("t6_post_wb_we", wb_we, 0);
        chk("t6_post_cnt", stall_cycles, 0);
        nop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
